// File: rtl/clock_edit_ctrl.sv
// clock_edit_ctrl: turns debounced buttons into edit-block pulses and field load strobes.
// Optional auto-repeat of up/down is built when CLOCK_EDIT_CTRL_AUTOREPEAT_EN is defined.
module clock_edit_ctrl #(
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_MS        = 250,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick_ms,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic [1:0] i_edit_sel,
  input  logic [7:0] i_edit_val,
  output logic       o_ena,
  output logic       o_wr_pulse,
  output logic       o_val_inc_pulse,
  output logic       o_val_dec_pulse,
  output logic       o_sel_inc_pulse,
  output logic       o_sel_dec_pulse,
  output logic [3:0] o_load,
  output logic [7:0] o_load_val,
  output logic       o_editing,
  output logic       o_blink,
  output logic       o_timeout
);
  typedef enum logic [2:0] {IDLE, ENTER, EDIT, COMMIT_SEL, SEL, COMMIT_EXIT, EXIT, ABORT} state_t;
  state_t state, nxt;
  logic [4:0] btn, prev, press;
  logic live, dir, acc, rep_fire, blink, n_vi, n_vd;
  logic [3:0] load;
  logic [7:0] load_val;
  logic [15:0] to_cnt, bl_cnt;
  assign btn = {i_btn_mode, i_btn_left, i_btn_right, i_btn_up, i_btn_down};
  // live masks the first cycle after reset so a held button is not seen as a press
  assign press = btn & ~prev & {5{live}};
  always_comb begin
    nxt = state;
    acc = 1'b0;
    n_vi = 1'b0;
    n_vd = 1'b0;
    case (state)
      IDLE:        nxt = press[4] ? ENTER : IDLE;
      ENTER:       nxt = EDIT;
      EDIT:
        if (press[4]) begin
          nxt = COMMIT_EXIT;
          acc = 1'b1;
        end else if (press[3] ^ press[2]) begin
          nxt = COMMIT_SEL;
          acc = 1'b1;
        end else if (press[1] ^ press[0]) begin
          n_vi = press[1];
          n_vd = press[0];
          acc = 1'b1;
        end else if (rep_fire) begin
          n_vi = i_btn_up;
          n_vd = i_btn_down;
        end else if (i_tick_ms && to_cnt == 16'(TIMEOUT_MS - 1)) nxt = ABORT;
      COMMIT_SEL:  nxt = SEL;
      SEL:         nxt = EDIT;
      COMMIT_EXIT: nxt = EXIT;
      default:     nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      prev <= '0;
      live <= 1'b0;
      dir <= 1'b0;
      {o_ena, o_editing, o_wr_pulse, o_val_inc_pulse, o_val_dec_pulse} <= '0;
      {o_sel_inc_pulse, o_sel_dec_pulse, o_timeout, blink} <= '0;
      load <= '0;
      load_val <= '0;
      to_cnt <= '0;
      bl_cnt <= '0;
    end else begin
      state <= nxt;
      prev <= btn;
      live <= 1'b1;
      if (state == EDIT && (press[3] ^ press[2])) dir <= press[2];
      o_ena <= nxt != IDLE;
      o_editing <= nxt != IDLE;
      o_wr_pulse <= nxt inside {ENTER, EXIT, ABORT};
      o_val_inc_pulse <= n_vi;
      o_val_dec_pulse <= n_vd;
      o_sel_inc_pulse <= nxt == SEL && dir;
      o_sel_dec_pulse <= nxt == SEL && !dir;
      o_timeout <= nxt == ABORT;
      load <= (nxt inside {COMMIT_SEL, COMMIT_EXIT}) ? 4'd1 << i_edit_sel : 4'd0;
      load_val <= (nxt inside {COMMIT_SEL, COMMIT_EXIT}) ? i_edit_val : 8'd0;
      to_cnt <= (state != EDIT || nxt != EDIT || acc || rep_fire) ? 16'd0 : to_cnt + 16'(i_tick_ms);
      if (state != EDIT || nxt != EDIT) begin
        bl_cnt <= '0;
        blink <= 1'b0;
      end else if (i_tick_ms) begin
        bl_cnt <= (bl_cnt == 16'(BLINK_MS - 1)) ? 16'd0 : bl_cnt + 16'd1;
        blink <= blink ^ (bl_cnt == 16'(BLINK_MS - 1));
      end
    end
  end
`ifdef CLOCK_EDIT_CTRL_AUTOREPEAT_EN
  logic [15:0] rep_cnt;
  logic rep_first, hold;
  assign hold = state == EDIT && (i_btn_up ^ i_btn_down);
  assign rep_fire = hold && i_tick_ms &&
                    rep_cnt == (rep_first ? 16'(REPEAT_DELAY_MS - 1) : 16'(REPEAT_RATE_MS - 1));
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !hold) begin
      rep_cnt <= '0;
      rep_first <= 1'b1;
    end else if (i_tick_ms) begin
      rep_cnt <= rep_fire ? 16'd0 : rep_cnt + 16'd1;
      rep_first <= rep_first & ~rep_fire;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif
  // a reset asserted during a commit cycle must suppress the strobe immediately
  assign o_load = i_reset_n ? load : 4'd0;
  assign o_load_val = i_reset_n ? load_val : 8'd0;
  assign o_blink = blink;
endmodule

// File: tb/tb_clock_edit_ctrl.sv
// tb_clock_edit_ctrl: table-driven, scoreboarded check of clock_edit_ctrl.
module tb_clock_edit_ctrl;
`ifdef CLOCK_EDIT_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam logic [4:0] M = 5'b10000, L = 5'b01000, R = 5'b00100, U = 5'b00010, D = 5'b00001, N = 5'b0;
  localparam logic [4:0] W = 5'b10000, VI = 5'b01000, VD = 5'b00100, SI = 5'b00010, SD = 5'b00001, Z = 5'b0;
  typedef struct packed {
    logic ena, wr, vi, vd, si, sd;
    logic [3:0] ld;
    logic [7:0] lv;
    logic ed, bl, to;
  } out_t;
  typedef struct packed {
    logic rst_n;
    logic [4:0] btn;
    logic tick;
    logic [1:0] sel;
    logic [7:0] val;
    out_t exp;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0;
  logic b_mode = 1'b0, b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;
  logic [1:0] sel = '0;
  logic [7:0] val = '0;
  logic o_ena, o_wr_pulse, o_val_inc_pulse, o_val_dec_pulse, o_sel_inc_pulse, o_sel_dec_pulse;
  logic o_editing, o_blink, o_timeout;
  logic [3:0] o_load;
  logic [7:0] o_load_val;
  out_t act, e;
  vec_t tv[$];
  out_t sb[$];
  int id_q[$];
  int checks = 0, fails = 0, vi_cnt = 0, rep_lo = 0, rep_hi = 0, id = 0;
  clock_edit_ctrl #(.TIMEOUT_MS(10), .BLINK_MS(2), .REPEAT_DELAY_MS(3), .REPEAT_RATE_MS(2)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick_ms(tick),
    .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_down), .i_btn_left(b_left), .i_btn_right(b_right),
    .i_edit_sel(sel), .i_edit_val(val),
    .o_ena(o_ena), .o_wr_pulse(o_wr_pulse), .o_val_inc_pulse(o_val_inc_pulse), .o_val_dec_pulse(o_val_dec_pulse),
    .o_sel_inc_pulse(o_sel_inc_pulse), .o_sel_dec_pulse(o_sel_dec_pulse), .o_load(o_load), .o_load_val(o_load_val),
    .o_editing(o_editing), .o_blink(o_blink), .o_timeout(o_timeout)
  );
  assign act = {o_ena, o_wr_pulse, o_val_inc_pulse, o_val_dec_pulse, o_sel_inc_pulse, o_sel_dec_pulse,
                o_load, o_load_val, o_editing, o_blink, o_timeout};
  always #5 clk = ~clk;
  function automatic out_t ed(input logic [4:0] p, input logic bl);
    return {1'b1, p, 4'b0, 8'h0, 1'b1, bl, 1'b0};
  endfunction
  function automatic out_t ldo(input logic [3:0] l, input logic [7:0] v);
    return {1'b1, 5'b0, l, v, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic void add(input logic r, input logic [4:0] b, input logic t, input logic [1:0] s,
                              input logic [7:0] v, input out_t x);
    tv.push_back('{r, b, t, s, v, x});
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    // reset with mode held, then release: no press
    add(0, M, 0, 0, 0, '0);
    add(0, M, 0, 0, 0, '0);
    add(1, M, 0, 0, 0, '0);
    add(1, M, 0, 0, 0, '0);
    add(1, N, 0, 0, 0, '0);
    add(1, M, 0, 0, 0, ed(W, 0));
    add(1, M, 0, 0, 0, ed(Z, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    add(1, U | D, 0, 0, 0, ed(Z, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    add(1, U, 0, 0, 0, ed(VI, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    add(1, D, 0, 0, 0, ed(VD, 0));
    add(1, N, 0, 1, 8'h42, ed(Z, 0));
    add(1, R, 0, 1, 8'h42, ldo(4'b0010, 8'h42));
    add(1, R, 0, 1, 8'h42, ed(SI, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    add(1, L, 0, 2, 8'h17, ldo(4'b0100, 8'h17));
    add(1, N, 0, 0, 0, ed(SD, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    // blink with half-period 2 ticks
    add(1, N, 1, 0, 0, ed(Z, 0));
    add(1, N, 1, 0, 0, ed(Z, 1));
    add(1, N, 0, 0, 0, ed(Z, 1));
    add(1, N, 1, 0, 0, ed(Z, 1));
    add(1, N, 1, 0, 0, ed(Z, 0));
    add(1, U, 0, 0, 0, ed(VI, 0));
    // mode and left together: exit only
    add(1, M | L, 0, 3, 8'h09, ldo(4'b1000, 8'h09));
    add(1, N, 0, 0, 0, ed(W, 0));
    add(1, N, 0, 0, 0, '0);
    // inactivity timeout after 10 ticks
    add(1, M, 0, 0, 0, ed(W, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    for (int k = 1; k <= 9; k++) add(1, N, 1, 0, 0, ed(Z, 1'((k / 2) % 2)));
    add(1, N, 1, 0, 0, {1'b1, W, 4'b0, 8'h0, 1'b1, 1'b0, 1'b1});
    add(1, N, 0, 0, 0, '0);
    // up held across 9 ticks, released on the 9th
    add(1, M, 0, 0, 0, ed(W, 0));
    add(1, N, 0, 0, 0, ed(Z, 0));
    rep_lo = tv.size();
    add(1, U, 0, 0, 0, ed(VI, 0));
    for (int k = 1; k <= 8; k++)
      add(1, U, 1, 0, 0, ed((AR && (k == 3 || k == 5 || k == 7)) ? VI : Z, 1'((k / 2) % 2)));
    add(1, N, 1, 0, 0, ed(Z, 0));
    rep_hi = tv.size() - 1;
    add(1, M, 0, 0, 8'h33, ldo(4'b0001, 8'h33));
    foreach (tv[i]) begin
      @(negedge clk);
      reset_n = tv[i].rst_n;
      {b_mode, b_left, b_right, b_up, b_down} = tv[i].btn;
      tick = tv[i].tick;
      sel = tv[i].sel;
      val = tv[i].val;
      sb.push_back(tv[i].exp);
      id_q.push_back(i);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      id = id_q.pop_front();
      chk($sformatf("row%0d", id), 32'(act), 32'(e));
      if (id >= rep_lo && id <= rep_hi) vi_cnt += int'(o_val_inc_pulse);
    end
    // now in COMMIT_EXIT: reset mid-cycle kills the load and the exit write
    #1 reset_n = 1'b0;
    #1 chk("rst_in_commit_load", {o_load, o_load_val}, 0);
    @(posedge clk);
    #1 chk("rst_in_commit_idle", 32'(act), 0);
    @(negedge clk);
    reset_n = 1'b1;
    {b_mode, b_left, b_right, b_up, b_down} = '0;
    @(posedge clk);
    #1 chk("post_reset_idle", 32'(act), 0);
    chk("repeat_count", vi_cnt, AR ? 4 : 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/clock_edit_ctrl.md
# clock_edit_ctrl

Sequencer for the clock edit datapath. Turns debounced push-button levels into the single-cycle write, select and value pulses the edit block consumes. Commits each edited field back to the timekeeping counters through one-hot load strobes. Also provides inactivity timeout, display blink and optional auto-repeat. It sits between the button debouncers and the edit block / time counters in the clock top level.

## Interface
Parameters:
- TIMEOUT_MS, 10000, inactivity time in EDIT before abort (1..65535)
- BLINK_MS, 250, half-period of o_blink in EDIT (1..65535)
- REPEAT_DELAY_MS, 500, hold time before first auto-repeat
- REPEAT_RATE_MS, 100, auto-repeat interval

Ports:
- i_clk  in  1  system clock; the only clock
- i_reset_n  in  1  synchronous reset, active-low; sampled on rising i_clk
- i_tick_ms  in  1  one-cycle strobe every 1 ms
- i_btn_mode, i_btn_up, i_btn_down, i_btn_left, i_btn_right  in  1 each  debounced button levels, 1 = pressed
- i_edit_sel  in  2  field currently selected by the edit block (0 ss, 1 mm, 2 hh, 3 pm)
- i_edit_val  in  8  value currently held by the edit block
- o_ena  out  1  edit-block enable
- o_wr_pulse  out  1  toggles edit-block write mode
- o_val_inc_pulse, o_val_dec_pulse  out  1 each  value step requests
- o_sel_inc_pulse (right), o_sel_dec_pulse (left)  out  1 each  field step requests
- o_load  out  4  one-hot field load strobe; bit = i_edit_sel
- o_load_val  out  8  data for o_load
- o_editing  out  1  high in every state except IDLE
- o_blink  out  1  display blink phase
- o_timeout  out  1  one-cycle flag on abort

## Operation
- Press = rising edge of a button level, detected against a registered copy. Only presses act; holds matter only for auto-repeat.
- Priority within a cycle: mode > left/right > up/down.
- left+right together: both ignored. up+down together: both ignored.
- At most one of o_wr_pulse, o_val_*, o_sel_*, o_load is nonzero in any cycle.
- States:
  - IDLE: mode press -> ENTER; all other presses ignored.
  - ENTER: o_wr_pulse=1, o_ena=1 -> EDIT.
  - EDIT: o_ena=1.
    - up/down press: o_val_inc/dec_pulse next cycle, stay.
    - left/right press -> COMMIT_SEL.
    - mode press -> COMMIT_EXIT.
    - timeout -> ABORT.
  - COMMIT_SEL: o_load[i_edit_sel]=1, o_load_val=i_edit_val -> SEL.
  - SEL: o_sel_inc_pulse (right) or o_sel_dec_pulse (left); direction is latched at the press -> EDIT.
  - COMMIT_EXIT: load as in COMMIT_SEL -> EXIT.
  - EXIT: o_wr_pulse=1 -> IDLE.
  - ABORT: o_wr_pulse=1, o_timeout=1, no load -> IDLE.
- Presses arriving in ENTER, COMMIT_*, SEL, EXIT or ABORT are dropped. They are not queued.
- Timeout counter:
  - 16-bit; counts i_tick_ms only in EDIT.
  - Cleared on entry to EDIT and on every accepted press.
  - Reaching TIMEOUT_MS raises the timeout.
- Blink counter:
  - 16-bit; counts i_tick_ms in EDIT.
  - o_blink toggles and the counter clears on reaching BLINK_MS.
  - Outside EDIT: counter cleared, o_blink=0.

## Timing
- Reset (i_reset_n=0 at an edge): state IDLE, all outputs 0, counters 0, button history 0. A button already held at reset release does not count as a press.
- Reset mid-sequence, including a COMMIT state: return to IDLE with no load issued.
- Press latency: level first high in cycle N -> request pulse in cycle N+1.
- Sel press: load in N+1, sel pulse in N+2, back in EDIT at N+3.
- Mode exit: load in N+1, o_wr_pulse in N+2, IDLE at N+3.
- Mode entry: o_wr_pulse in N+1, EDIT at N+2.
- All pulses last exactly one cycle.
- o_load_val is valid only while o_load is nonzero, and is 0 otherwise.

## Configuration
- CLOCK_EDIT_CTRL_AUTOREPEAT_EN defined:
  - Applies in EDIT while exactly one of up/down is held.
  - After REPEAT_DELAY_MS ticks: an additional val pulse in that direction.
  - Then another every REPEAT_RATE_MS ticks while the button stays held.
  - Each repeat clears the timeout counter.
  - The repeat counter clears on release, on leaving EDIT, or when both buttons are held.
- Macro undefined: no repeat logic; one val pulse per press only.

## Test plan
- Reset release with i_btn_mode held -> stays IDLE, no o_wr_pulse. Release then press mode -> o_wr_pulse one cycle later, o_editing=1.
- In EDIT, i_edit_sel=1, i_edit_val=8'h42, press right:
  - next cycle o_load=4'b0010 with o_load_val=8'h42;
  - following cycle o_sel_inc_pulse=1.
- In EDIT, press up and down in the same cycle -> no pulses. Press left and mode in the same cycle -> exit sequence only (load, then o_wr_pulse), no sel pulse.
- TIMEOUT_MS=5 with 5 i_tick_ms strobes and no press -> o_wr_pulse and o_timeout in the same cycle, o_load stays 0, then IDLE.
- With the macro defined, REPEAT_DELAY_MS=3, REPEAT_RATE_MS=2, up held for 9 ticks -> 4 o_val_inc_pulse: the press, then ticks 3, 5 and 7. Without the macro -> exactly 1.
- Deassert i_reset_n in the COMMIT_EXIT cycle -> o_load=0 that cycle, IDLE next, no o_wr_pulse.
